// File: rtl/nes_bus_pkg.sv
// Shared definitions for the 2A03 CPU bus responder: address map limits,
// the default OAM DMA trigger address, DMA state encoding and the region decoder.
package nes_bus_pkg;

    // Upper bound of each CPU address region; regions are contiguous from $0000.
    localparam logic [15:0] RAM_LIMIT  = 16'h1FFF;
    localparam logic [15:0] PPU_LIMIT  = 16'h3FFF;
    localparam logic [15:0] OPEN_LIMIT = 16'h7FFF;

    // Write to this address starts an OAM DMA transfer.
    localparam logic [15:0] DMA_ADDR_DEFAULT = 16'h4014;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_e;

    typedef enum logic [1:0] {
        SRC_RAM,
        SRC_PPU,
        SRC_OPEN,
        SRC_PRG
    } bus_src_e;

    // Map an effective address onto the device that answers it.
    function automatic bus_src_e decode_region(input logic [15:0] addr);
        bus_src_e src;
        if (addr <= RAM_LIMIT) begin
            src = SRC_RAM;
        end else if (addr <= PPU_LIMIT) begin
            src = SRC_PPU;
        end else if (addr <= OPEN_LIMIT) begin
            src = SRC_OPEN;
        end else begin
            src = SRC_PRG;
        end
        return src;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus plus the ROM, PPU register and OAM ports of the responder.
// The slave modport is the responder's view; master is the CPU/system view.
interface cpu_bus_responder_if #(
    parameter int PRG_AW = 15
);
    logic [15:0]       Addr_bus;
    logic [7:0]        Data_bus_out;
    logic              R_nW;
    logic [7:0]        Data_bus_in;
    logic              cpu_rdy;
    logic [PRG_AW-1:0] prg_addr;
    logic [7:0]        prg_data;
    logic              ppu_cs;
    logic [2:0]        ppu_reg;
    logic [7:0]        ppu_rdata;
    logic              oam_we;
    logic [7:0]        oam_data;

    modport slave (
        input  Addr_bus, Data_bus_out, R_nW, prg_data, ppu_rdata,
        output Data_bus_in, cpu_rdy, prg_addr, ppu_cs, ppu_reg, oam_we, oam_data
    );

    modport master (
        output Addr_bus, Data_bus_out, R_nW, prg_data, ppu_rdata,
        input  Data_bus_in, cpu_rdy, prg_addr, ppu_cs, ppu_reg, oam_we, oam_data
    );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies one 256-byte page into OAM, stalling the CPU while
// it runs. Owns the cycle-parity flop that decides the 513/514 cycle length.
module oam_dma_engine
    import nes_bus_pkg::*;
(
    input  logic        clk_ph2,
    input  logic        rst,          // asynchronous, active low
    input  logic        trig_i,       // CPU write to the DMA trigger address
    input  logic [7:0]  wdata_i,      // page number written by the CPU
    input  logic [7:0]  rdata_i,      // decoded read data for the DMA source
    output logic        dma_active_o,
    output logic        dma_read_o,
    output logic [15:0] dma_addr_o,
    output logic        cpu_rdy_o,
    output logic        oam_we_o,
    output logic [7:0]  oam_data_o
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] oam_data_q, oam_data_d;
    logic       extra_q, extra_d;     // one more ALIGN cycle still owed
    logic       parity_q;
    logic       cpu_rdy_q;
    logic       oam_we_q;

    // Free-running cycle parity, started from reset.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end

    // Next-state logic: trigger, alignment, then 256 read/write pairs.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        extra_d    = extra_q;
        oam_data_d = oam_data_q;
        case (state_q)
            DMA_IDLE: begin
                if (trig_i) begin
                    page_d  = wdata_i;
                    cnt_d   = 8'h00;
                    extra_d = parity_q;
                    state_d = DMA_ALIGN;
                end
            end
            DMA_ALIGN: begin
                if (extra_q) begin
                    extra_d = 1'b0;
                end else begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                oam_data_d = rdata_i;
                state_d    = DMA_WRITE;
            end
            DMA_WRITE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == 8'hFF) ? DMA_IDLE : DMA_READ;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // State registers; cpu_rdy and oam_we are registered from the next state.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            state_q    <= DMA_IDLE;
            page_q     <= 8'h00;
            cnt_q      <= 8'h00;
            extra_q    <= 1'b0;
            oam_data_q <= 8'h00;
            cpu_rdy_q  <= 1'b1;
            oam_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            extra_q    <= extra_d;
            oam_data_q <= oam_data_d;
            cpu_rdy_q  <= (state_d == DMA_IDLE);
            oam_we_q   <= (state_d == DMA_WRITE);
        end
    end

    assign dma_active_o = (state_q != DMA_IDLE);
    assign dma_read_o   = (state_q == DMA_READ);
    assign dma_addr_o   = {page_q, cnt_q};
    assign cpu_rdy_o    = cpu_rdy_q;
    assign oam_we_o     = oam_we_q;
    assign oam_data_o   = oam_data_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 2A03 CPU bus: work RAM, PRG ROM port, PPU
// register select, open-bus latch, and the OAM DMA engine that can take over
// the address bus.
module cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int          RAM_AW   = 11,
    parameter int          PRG_AW   = 15,
    parameter logic [15:0] DMA_ADDR = DMA_ADDR_DEFAULT
) (
    input  logic                clk_ph2,
    input  logic                rst,          // asynchronous, active low
    cpu_bus_responder_if.slave  bus
);

    logic [7:0]  ram_q [0:(1 << RAM_AW) - 1];
    logic [7:0]  open_q, open_d;
    logic [15:0] eff_addr;
    bus_src_e    src;
    logic [7:0]  ram_rdata;
    logic [7:0]  rd_data;
    logic        dma_active;
    logic        dma_read;
    logic [15:0] dma_addr;
    logic        cpu_wr;
    logic        dma_trig;

    // CPU writes are dropped entirely while DMA owns the bus.
    assign cpu_wr   = !bus.R_nW && !dma_active;
    assign dma_trig = cpu_wr && (bus.Addr_bus == DMA_ADDR);

    oam_dma_engine u_dma (
        .clk_ph2      (clk_ph2),
        .rst          (rst),
        .trig_i       (dma_trig),
        .wdata_i      (bus.Data_bus_out),
        .rdata_i      (rd_data),
        .dma_active_o (dma_active),
        .dma_read_o   (dma_read),
        .dma_addr_o   (dma_addr),
        .cpu_rdy_o    (bus.cpu_rdy),
        .oam_we_o     (bus.oam_we),
        .oam_data_o   (bus.oam_data)
    );

    assign eff_addr  = dma_read ? dma_addr : bus.Addr_bus;
    assign src       = decode_region(eff_addr);
    assign ram_rdata = ram_q[eff_addr[RAM_AW-1:0]];

    // Read-data mux for whichever device the effective address selects.
    always_comb begin
        rd_data = open_q;
        case (src)
            SRC_RAM:  rd_data = ram_rdata;
            SRC_PPU:  rd_data = bus.ppu_rdata;
            SRC_OPEN: rd_data = open_q;
            SRC_PRG:  rd_data = bus.prg_data;
            default:  rd_data = open_q;
        endcase
    end

    assign bus.Data_bus_in = rd_data;
    assign bus.prg_addr    = eff_addr[PRG_AW-1:0];
    assign bus.ppu_reg     = eff_addr[2:0];
    // A stalled CPU address must not touch PPU registers; only DMA reads may.
    assign bus.ppu_cs      = (src == SRC_PPU) && (!dma_active || dma_read);

    // Work RAM write port; contents survive reset.
    always_ff @(posedge clk_ph2) begin
        if (cpu_wr && (src == SRC_RAM)) begin
            ram_q[eff_addr[RAM_AW-1:0]] <= bus.Data_bus_out;
        end
    end

    // Open-bus latch follows whatever was last driven on the data bus.
    always_comb begin
        open_d = (dma_active || bus.R_nW) ? rd_data : bus.Data_bus_out;
    end

    // Open-bus latch register.
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            open_q <= 8'h00;
        end else begin
            open_q <= open_d;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: table of single-cycle bus accesses,
// then hand-written OAM DMA sequences (even/odd trigger, reset mid-transfer).
module tb_cpu_bus_responder;

    localparam int PRG_AW = 14;
    localparam int NV     = 17;

    logic clk_ph2 = 1'b0;
    logic rst     = 1'b0;
    logic tb_par;
    int   checks   = 0;
    int   failures = 0;

    cpu_bus_responder_if #(.PRG_AW(PRG_AW)) bus_if ();

    cpu_bus_responder #(
        .RAM_AW   (11),
        .PRG_AW   (PRG_AW),
        .DMA_ADDR (16'h4014)
    ) dut (
        .clk_ph2 (clk_ph2),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 clk_ph2 = ~clk_ph2;

    // ROM returns the low address byte; PPU returns $A0 | register number.
    assign bus_if.prg_data  = bus_if.prg_addr[7:0];
    assign bus_if.ppu_rdata = {5'b10100, bus_if.ppu_reg};

    // Reference cycle parity counted from reset release.
    always @(posedge clk_ph2 or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rnw;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        exp_cs;
        logic        chk_prg;
        logic [13:0] exp_prg;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus_if.Addr_bus     = 16'h8000;
        bus_if.Data_bus_out = 8'h00;
        bus_if.R_nW         = 1'b1;
    endtask

    // par_sel: 0 = trigger on even cycle, 1 = odd, 2 = whichever comes next.
    task automatic run_dma(input string tag, input int par_sel, input bit poke);
        int   stall;
        int   pulses;
        int   guard;
        logic trig_par;
        @(negedge clk_ph2);
        drive_idle();
        guard = 0;
        while (par_sel != 2 && tb_par != par_sel[0] && guard < 4) begin
            @(negedge clk_ph2);
            guard++;
        end
        trig_par            = tb_par;
        bus_if.Addr_bus     = 16'h4014;
        bus_if.Data_bus_out = 8'h02;
        bus_if.R_nW         = 1'b0;
        @(negedge clk_ph2);
        drive_idle();
        stall  = 0;
        pulses = 0;
        guard  = 0;
        while (guard < 1200) begin
            #1;
            if (bus_if.cpu_rdy === 1'b0) stall++;
            if (bus_if.oam_we === 1'b1) begin
                if (pulses < 256)
                    check($sformatf("%s_oam%0d", tag, pulses), {24'h0, bus_if.oam_data},
                          {24'h0, pulses[7:0] ^ 8'h3C});
                pulses++;
            end
            if (bus_if.cpu_rdy === 1'b1 && guard > 0) break;
            if (poke && guard == 100) begin
                bus_if.Addr_bus     = 16'h0000;
                bus_if.Data_bus_out = 8'hFF;
                bus_if.R_nW         = 1'b0;
            end
            guard++;
            @(negedge clk_ph2);
            drive_idle();
        end
        check({tag, "_done"}, (guard < 1200) ? 32'd1 : 32'd0, 32'd1);
        check({tag, "_stall"}, stall, 513 + int'(trig_par));
        check({tag, "_pulses"}, pulses, 256);
        $display("%s: trigger parity=%0d stall=%0d pulses=%0d", tag, trig_par, stall, pulses);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int pulses;
        //            addr     wdata  rnw  chk  exp    cs   chkp prg
        vecs[0]  = '{16'h0003, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 14'h0000};
        vecs[1]  = '{16'h0803, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 14'h0000};
        vecs[2]  = '{16'h1803, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 14'h0000};
        vecs[3]  = '{16'h8042, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 14'h0042};
        vecs[4]  = '{16'hC042, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 14'h0042};
        vecs[5]  = '{16'h805C, 8'h00, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b1, 14'h005C};
        vecs[6]  = '{16'h5000, 8'h00, 1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 14'h0000};
        vecs[7]  = '{16'h6000, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 14'h0000};
        vecs[8]  = '{16'h5000, 8'h00, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 14'h0000};
        vecs[9]  = '{16'h2002, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 14'h0000};
        vecs[10] = '{16'h3FFF, 8'h00, 1'b1, 1'b1, 8'hA7, 1'b1, 1'b0, 14'h0000};
        vecs[11] = '{16'h4015, 8'h00, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b0, 14'h0000};
        vecs[12] = '{16'h8000, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 14'h0000};
        vecs[13] = '{16'h7FFF, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 14'h0000};
        vecs[14] = '{16'h0003, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 14'h0000};
        vecs[15] = '{16'h0000, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 14'h0000};
        vecs[16] = '{16'h0000, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 14'h0000};

        // Reset state.
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk_ph2);
        #1;
        check("reset_cpu_rdy", {31'h0, bus_if.cpu_rdy}, 32'd1);
        check("reset_oam_we", {31'h0, bus_if.oam_we}, 32'd0);
        check("reset_oam_data", {24'h0, bus_if.oam_data}, 32'h00);
        @(negedge clk_ph2);
        rst = 1'b1;
        bus_if.Addr_bus = 16'h5000;
        #1;
        check("reset_open_bus", {24'h0, bus_if.Data_bus_in}, 32'h00);
        $display("reset: cpu_rdy=%0b oam_we=%0b open_bus=%02h", bus_if.cpu_rdy, bus_if.oam_we,
                 bus_if.Data_bus_in);

        // Single-cycle accesses from the table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_ph2);
            bus_if.Addr_bus     = vecs[i].addr;
            bus_if.Data_bus_out = vecs[i].wdata;
            bus_if.R_nW         = vecs[i].rnw;
            #1;
            check($sformatf("vec%0d_cs", i), {31'h0, bus_if.ppu_cs}, {31'h0, vecs[i].exp_cs});
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rd", i), {24'h0, bus_if.Data_bus_in}, {24'h0, vecs[i].exp_rd});
            if (vecs[i].chk_prg)
                check($sformatf("vec%0d_prg", i), {18'h0, bus_if.prg_addr}, {18'h0, vecs[i].exp_prg});
            $display("vec%0d: addr=%04h rnw=%0b wdata=%02h rd=%02h cs=%0b prg=%04h", i,
                     vecs[i].addr, vecs[i].rnw, vecs[i].wdata, bus_if.Data_bus_in, bus_if.ppu_cs,
                     bus_if.prg_addr);
        end

        // Preload page $02 with i ^ $3C.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_ph2);
            bus_if.Addr_bus     = 16'h0200 + 16'(i);
            bus_if.Data_bus_out = 8'(i) ^ 8'h3C;
            bus_if.R_nW         = 1'b0;
        end
        $display("preload: page 02 written");

        run_dma("dma_even", 0, 1'b0);
        run_dma("dma_odd", 1, 1'b1);

        // The write to $0000 during the odd DMA must not have landed.
        @(negedge clk_ph2);
        bus_if.Addr_bus = 16'h0000;
        bus_if.R_nW     = 1'b1;
        #1;
        check("dma_ignored_write", {24'h0, bus_if.Data_bus_in}, 32'h11);
        $display("ram[0000] after dma: %02h", bus_if.Data_bus_in);

        // Reset in the middle of a transfer.
        @(negedge clk_ph2);
        bus_if.Addr_bus     = 16'h4014;
        bus_if.Data_bus_out = 8'h02;
        bus_if.R_nW         = 1'b0;
        pulses = 0;
        for (int g = 0; g < 200 && pulses < 40; g++) begin
            @(negedge clk_ph2);
            drive_idle();
            #1;
            if (bus_if.oam_we === 1'b1) pulses++;
        end
        check("midrst_pulses", pulses, 40);
        rst = 1'b0;
        #1;
        check("midrst_cpu_rdy", {31'h0, bus_if.cpu_rdy}, 32'd1);
        check("midrst_oam_we", {31'h0, bus_if.oam_we}, 32'd0);
        $display("mid-dma reset: pulses=%0d cpu_rdy=%0b oam_we=%0b", pulses, bus_if.cpu_rdy,
                 bus_if.oam_we);
        repeat (2) @(negedge clk_ph2);
        #1;
        check("midrst_hold_oam_we", {31'h0, bus_if.oam_we}, 32'd0);
        @(negedge clk_ph2);
        rst = 1'b1;
        run_dma("dma_after_rst", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
